// File: rtl/spect_scaler_pkg.sv
// spect_scaler_pkg: shared state encoding, divider length, DMA stride and magnitude helper.
package spect_scaler_pkg;
  typedef enum logic [2:0] {S_IDLE, S_IN, S_DIV1, S_DIV2, S_WR, S_DONE} state_t;
  localparam int DIV_CYCLES = 32;
  localparam logic [31:0] ADDR_STRIDE = 32'd4;
  // 0x8000 maps to 32768, which still fits the unsigned 16-bit result
  function automatic logic [15:0] mag16(input logic [15:0] x);
    return x[15] ? 16'(-x) : x;
  endfunction
endpackage

// File: rtl/spect_scaler_div.sv
// norm_div: restoring divider, 32-bit dividend / 16-bit divisor, one quotient bit per cycle.
// Ports: clk, rst (sync, active-high); start loads operands; divisor must stay stable
// while running; done is high in the final iteration cycle, with quotient valid alongside it.
module norm_div
  import spect_scaler_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] dividend,
  input  logic [15:0] divisor,
  output logic        done,
  output logic [31:0] quotient
);
  logic        busy_q, busy_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [15:0] rem_q, rem_d, rem_n;
  logic [31:0] quo_q, quo_d, quo_n;
  logic [16:0] rem_sh;
  logic        ge;
  always_comb begin
    rem_sh   = {rem_q, quo_q[31]};
    ge       = rem_sh >= {1'b0, divisor};
    // remainder stays below divisor, so bit 16 is zero whenever no subtraction occurs
    rem_n    = ge ? 16'(rem_sh - {1'b0, divisor}) : rem_sh[15:0];
    quo_n    = {quo_q[30:0], ge};
    done     = busy_q && cnt_q == 6'd1;
    quotient = quo_n;
    busy_d   = start || (busy_q && !done);
    cnt_d    = start ? 6'(DIV_CYCLES) : busy_q ? cnt_q - 6'd1 : cnt_q;
    rem_d    = start ? 16'd0 : busy_q ? rem_n : rem_q;
    quo_d    = start ? dividend : busy_q ? quo_n : quo_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      rem_q  <= rem_d;
      quo_q  <= quo_d;
    end
  end
endmodule

// File: rtl/spect_scaler.sv
// spect_scaler: rescales signed sample pairs by max_value/max_in and DMA-writes them.
// Ports: clk, rst (sync, active-high); start/len/dst_addr/max_in/max_value job config;
// spect_data_1/2 + spect_valid/spect_rdy sample input; dma_addr/dma_write/dma_writedata/dma_rdy
// write port; busy, done status.
// Macro SPECT_SCALER_SAT_EN: clamp magnitude result to max_value (default: no clamp).
module spect_scaler
  import spect_scaler_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] len,
  input  logic [31:0] dst_addr,
  input  logic [15:0] max_in,
  input  logic [15:0] max_value,
  input  logic [15:0] spect_data_1,
  input  logic [15:0] spect_data_2,
  input  logic        spect_valid,
  output logic        spect_rdy,
  output logic [31:0] dma_addr,
  output logic        dma_write,
  output logic [31:0] dma_writedata,
  input  logic        dma_rdy,
  output logic        busy,
  output logic        done
);
  state_t      state_q, state_d;
  logic [15:0] len_q, len_d, cnt_q, cnt_d, max_in_q, max_in_d, max_val_q, max_val_d;
  logic [15:0] s1_q, s1_d, s2_q, s2_d, res1_q, res1_d, res2_q, res2_d;
  logic [31:0] addr_q, addr_d;
  logic        launched_q, launched_d;
  logic [15:0] sel, mres, res;
  logic [31:0] num, div_q;
  logic        div_start, div_done, div_end, in_div;
  norm_div u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .dividend (num),
    .divisor  (max_in_q),
    .done     (div_done),
    .quotient (div_q)
  );
  always_comb begin
    in_div    = state_q == S_DIV1 || state_q == S_DIV2;
    sel       = state_q == S_DIV1 ? s1_q : s2_q;
    num       = 32'(mag16(sel)) * 32'(max_val_q);
    // zero peak skips the divider entirely and forces a zero result
    div_start = in_div && !launched_q && max_in_q != 16'd0;
    div_end   = max_in_q == 16'd0 || div_done;
`ifdef SPECT_SCALER_SAT_EN
    mres      = div_q > {16'd0, max_val_q} ? max_val_q : div_q[15:0];
`else
    mres      = div_q[15:0];
`endif
    res       = max_in_q == 16'd0 ? 16'd0 : sel[15] ? 16'(-mres) : mres;
  end
`ifndef SPECT_SCALER_SAT_EN
  logic unused_hi;
  assign unused_hi = ^div_q[31:16];
`endif
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = start ? (len == 16'd0 ? S_DONE : S_IN) : S_IDLE;
      S_IN:    state_d = spect_valid ? S_DIV1 : S_IN;
      S_DIV1:  state_d = div_end ? S_DIV2 : S_DIV1;
      S_DIV2:  state_d = div_end ? S_WR : S_DIV2;
      S_WR:    state_d = dma_rdy ? (cnt_q + 16'd1 == len_q ? S_DONE : S_IN) : S_WR;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end
  always_comb begin
    len_d      = (state_q == S_IDLE && start) ? len : len_q;
    addr_d     = (state_q == S_IDLE && start) ? dst_addr :
                 (state_q == S_WR && dma_rdy) ? addr_q + ADDR_STRIDE : addr_q;
    max_in_d   = (state_q == S_IDLE && start) ? max_in : max_in_q;
    max_val_d  = (state_q == S_IDLE && start) ? max_value : max_val_q;
    cnt_d      = (state_q == S_IDLE && start) ? 16'd0 :
                 (state_q == S_WR && dma_rdy) ? cnt_q + 16'd1 : cnt_q;
    s1_d       = (state_q == S_IN && spect_valid) ? spect_data_1 : s1_q;
    s2_d       = (state_q == S_IN && spect_valid) ? spect_data_2 : s2_q;
    res1_d     = (state_q == S_DIV1 && div_end) ? res : res1_q;
    res2_d     = (state_q == S_DIV2 && div_end) ? res : res2_q;
    launched_d = div_start ? 1'b1 : (in_div && div_end) ? 1'b0 : launched_q;
  end
  always_comb begin
    spect_rdy     = state_q == S_IN;
    busy          = state_q != S_IDLE;
    done          = state_q == S_DONE;
    dma_write     = state_q == S_WR;
    dma_addr      = state_q == S_WR ? addr_q : 32'd0;
    dma_writedata = state_q == S_WR ? {res1_q, res2_q} : 32'd0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      cnt_q      <= '0;
      addr_q     <= '0;
      max_in_q   <= '0;
      max_val_q  <= '0;
      s1_q       <= '0;
      s2_q       <= '0;
      res1_q     <= '0;
      res2_q     <= '0;
      launched_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      max_in_q   <= max_in_d;
      max_val_q  <= max_val_d;
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      res1_q     <= res1_d;
      res2_q     <= res2_d;
      launched_q <= launched_d;
    end
  end
endmodule

// File: tb/tb_spect_scaler.sv
// tb_spect_scaler: directed self-checking bench for spect_scaler.
module tb_spect_scaler;
  logic        clk = 1'b0;
  logic        rst, start, spect_valid, dma_rdy;
  logic [15:0] len, max_in, max_value, spect_data_1, spect_data_2;
  logic [31:0] dst_addr;
  logic        spect_rdy, dma_write, busy, done;
  logic [31:0] dma_addr, dma_writedata;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  spect_scaler dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .dst_addr(dst_addr),
    .max_in(max_in), .max_value(max_value),
    .spect_data_1(spect_data_1), .spect_data_2(spect_data_2),
    .spect_valid(spect_valid), .spect_rdy(spect_rdy),
    .dma_addr(dma_addr), .dma_write(dma_write), .dma_writedata(dma_writedata),
    .dma_rdy(dma_rdy), .busy(busy), .done(done)
  );
  task automatic launch(input logic [15:0] l, input logic [31:0] d, input logic [15:0] mi, input logic [15:0] mv);
    start = 1; len = l; dst_addr = d; max_in = mi; max_value = mv;
    @(negedge clk);
    start = 0; len = 16'hAAAA; dst_addr = 32'h5555_5555; max_in = 16'h3333; max_value = 16'h4444;
  endtask
  task automatic feed(input logic [15:0] a, input logic [15:0] b, output bit ok);
    ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      if (spect_rdy === 1'b1) ok = 1;
      else @(negedge clk);
    end
    spect_data_1 = a; spect_data_2 = b; spect_valid = ok;
    @(negedge clk);
    spect_valid = 0;
  endtask
  task automatic wait_wr(output bit ok);
    ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      if (dma_write === 1'b1) ok = 1;
      else @(negedge clk);
    end
  endtask
  task automatic test_reset;
    rst = 1;
    repeat (2) @(negedge clk);
    checks++;
    if ({spect_rdy, dma_write, busy, done} !== 4'b0) begin
      errors++; $display("FAIL reset_flags: got %b expected 0000", {spect_rdy, dma_write, busy, done});
    end
    checks++;
    if ({dma_addr, dma_writedata} !== 64'd0) begin
      errors++; $display("FAIL reset_dma: got %h expected 0", {dma_addr, dma_writedata});
    end
    rst = 0;
    @(negedge clk);
  endtask
  task automatic test_basic;
    bit ok;
    launch(16'd1, 32'h1000_0000, 16'h1000, 16'h7FFF);
    checks++;
    if (busy !== 1'b1 || spect_rdy !== 1'b1) begin
      errors++; $display("FAIL basic_in: got busy=%b rdy=%b expected 1 1", busy, spect_rdy);
    end
    feed(16'h0800, 16'hF800, ok);
    wait_wr(ok);
    checks++;
    if (!ok || dma_addr !== 32'h1000_0000) begin
      errors++; $display("FAIL basic_addr: got %h (seen=%b) expected 10000000", dma_addr, ok);
    end
    checks++;
    if (dma_writedata !== 32'h3FFF_C001) begin
      errors++; $display("FAIL basic_data: got %h expected 3fffc001", dma_writedata);
    end
    dma_rdy = 1;
    @(negedge clk);
    dma_rdy = 0;
    checks++;
    if (done !== 1'b1 || dma_write !== 1'b0) begin
      errors++; $display("FAIL basic_done: got done=%b wr=%b expected 1 0", done, dma_write);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL basic_idle: got done=%b busy=%b expected 0 0", done, busy);
    end
  endtask
  task automatic test_zero_div;
    bit ok;
    launch(16'd1, 32'h0000_2000, 16'h0000, 16'h7FFF);
    feed(16'h1234, 16'h8000, ok);
    repeat (2) @(negedge clk);
    checks++;
    if (dma_write !== 1'b1 || dma_writedata !== 32'd0 || dma_addr !== 32'h2000) begin
      errors++; $display("FAIL zero_div_write: got wr=%b data=%h addr=%h expected 1 0 2000", dma_write, dma_writedata, dma_addr);
    end
    dma_rdy = 1;
    @(negedge clk);
    dma_rdy = 0;
    checks++;
    if (done !== 1'b1) begin
      errors++; $display("FAIL zero_div_done: got %b expected 1", done);
    end
    @(negedge clk);
    launch(16'd0, 32'h0000_9000, 16'h1000, 16'h1000);
    checks++;
    if (done !== 1'b1 || dma_write !== 1'b0) begin
      errors++; $display("FAIL len0_done: got done=%b wr=%b expected 1 0", done, dma_write);
    end
    @(negedge clk);
  endtask
  task automatic test_sat;
    bit ok;
    logic [31:0] exp;
`ifdef SPECT_SCALER_SAT_EN
    exp = 32'h7FFF_8001;
`else
    exp = 32'hFFFE_0002;
`endif
    launch(16'd1, 32'h0000_3000, 16'h1000, 16'h7FFF);
    feed(16'h2000, 16'hE000, ok);
    wait_wr(ok);
    checks++;
    if (!ok || dma_writedata !== exp) begin
      errors++; $display("FAIL sat_data: got %h (seen=%b) expected %h", dma_writedata, ok, exp);
    end
    dma_rdy = 1;
    @(negedge clk);
    dma_rdy = 0;
    @(negedge clk);
  endtask
  task automatic test_wrap;
    bit ok, stable;
    logic [31:0] ea [3];
    logic [15:0] ev [3];
    ea[0] = 32'hFFFF_FFFC; ea[1] = 32'h0; ea[2] = 32'h4;
    ev[0] = 16'h0011; ev[1] = 16'h0222; ev[2] = 16'h7FFF;
    launch(16'd3, 32'hFFFF_FFFC, 16'h7FFF, 16'h7FFF);
    for (int w = 0; w < 3; w++) begin
      feed(ev[w], 16'(-ev[w]), ok);
      wait_wr(ok);
      checks++;
      if (!ok || dma_addr !== ea[w] || dma_writedata !== {ev[w], 16'(-ev[w])}) begin
        errors++; $display("FAIL wrap_word%0d: got addr=%h data=%h expected %h %h", w, dma_addr, dma_writedata, ea[w], {ev[w], 16'(-ev[w])});
      end
      stable = 1;
      repeat (5) begin
        @(negedge clk);
        if (dma_write !== 1'b1 || dma_addr !== ea[w] || dma_writedata !== {ev[w], 16'(-ev[w])}) stable = 0;
      end
      checks++;
      if (!stable) begin
        errors++; $display("FAIL wrap_hold%0d: got unstable write, expected held addr=%h", w, ea[w]);
      end
      dma_rdy = 1;
      @(negedge clk);
      dma_rdy = 0;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++; $display("FAIL wrap_done: got %b expected 1", done);
    end
    @(negedge clk);
  endtask
  task automatic test_valid_idle;
    bit ok, good;
    launch(16'd1, 32'h0000_5000, 16'h7FFF, 16'h7FFF);
    good = 1;
    for (int i = 0; i < 10; i++) begin
      if (spect_rdy !== 1'b1 || busy !== 1'b1 || dma_write !== 1'b0) good = 0;
      start = (i == 3); len = 16'd5; dst_addr = 32'hDEAD_0000;
      @(negedge clk);
      start = 0;
    end
    checks++;
    if (!good || spect_rdy !== 1'b1) begin
      errors++; $display("FAIL valid_idle_rdy: got rdy=%b expected held 1", spect_rdy);
    end
    feed(16'h0010, 16'h0020, ok);
    wait_wr(ok);
    checks++;
    if (!ok || dma_addr !== 32'h5000 || dma_writedata !== 32'h0010_0020) begin
      errors++; $display("FAIL start_ignored: got addr=%h data=%h expected 00005000 00100020", dma_addr, dma_writedata);
    end
    dma_rdy = 1;
    @(negedge clk);
    dma_rdy = 0;
    checks++;
    if (done !== 1'b1) begin
      errors++; $display("FAIL start_ignored_done: got %b expected 1", done);
    end
    @(negedge clk);
  endtask
  task automatic test_rst_mid;
    bit ok, quiet;
    launch(16'd1, 32'h0000_7000, 16'h1000, 16'h7FFF);
    feed(16'h0800, 16'h0800, ok);
    repeat (40) @(negedge clk);
    rst = 1;
    @(negedge clk);
    checks++;
    if ({spect_rdy, dma_write, busy, done} !== 4'b0 || {dma_addr, dma_writedata} !== 64'd0) begin
      errors++; $display("FAIL rst_mid_outputs: got flags=%b dma=%h expected 0", {spect_rdy, dma_write, busy, done}, {dma_addr, dma_writedata});
    end
    rst = 0;
    dma_rdy = 1;
    quiet = 1;
    repeat (80) begin
      @(negedge clk);
      if (dma_write !== 1'b0 || done !== 1'b0 || busy !== 1'b0) quiet = 0;
    end
    checks++;
    if (!quiet) begin
      errors++; $display("FAIL rst_mid_quiet: got activity after reset, expected idle");
    end
  endtask
  task automatic test_back_to_back;
    bit ok;
    logic [31:0] ed [2];
    logic [15:0] a [2];
    logic [15:0] b [2];
    a[0] = 16'h0064; b[0] = 16'hFF9C; ed[0] = 32'h0032_FFCE;
    a[1] = 16'h0003; b[1] = 16'hFFFD; ed[1] = 32'h0001_FFFF;
    launch(16'd2, 32'h0000_0040, 16'h0100, 16'h0080);
    for (int w = 0; w < 2; w++) begin
      feed(a[w], b[w], ok);
      wait_wr(ok);
      checks++;
      if (!ok || dma_addr !== 32'h40 + 32'(4 * w) || dma_writedata !== ed[w]) begin
        errors++; $display("FAIL b2b_word%0d: got addr=%h data=%h expected %h %h", w, dma_addr, dma_writedata, 32'h40 + 32'(4 * w), ed[w]);
      end
      @(negedge clk);
    end
    checks++;
    if (done !== 1'b1) begin
      errors++; $display("FAIL b2b_done: got %b expected 1", done);
    end
    dma_rdy = 0;
    @(negedge clk);
  endtask
  initial begin
    rst = 1; start = 0; spect_valid = 0; dma_rdy = 0;
    len = 0; dst_addr = 0; max_in = 0; max_value = 0; spect_data_1 = 0; spect_data_2 = 0;
    @(negedge clk);
    test_reset;
    test_basic;
    test_zero_div;
    test_sat;
    test_wrap;
    test_valid_idle;
    test_rst_mid;
    test_back_to_back;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/spect_scaler.md
SPECT_SCALER -- requirements
Module: spect_scaler

Interface
REQ-001 SHALL have port: clk  input  1  clock; all logic on rising edge.
REQ-002 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have ports: start  input  1  job start pulse; len  input  16  words per job; dst_addr  input  32  first DMA write address.
REQ-004 SHALL have ports: max_in  input  16  peak magnitude from normalizer; max_value  input  16  target full-scale magnitude.
REQ-005 SHALL have ports: spect_data_1, spect_data_2  input  16 each  signed samples; spect_valid  input  1; spect_rdy  output  1.
REQ-006 SHALL have ports: dma_addr  output  32; dma_write  output  1; dma_writedata  output  32; dma_rdy  input  1.
REQ-007 SHALL have ports: busy  output  1  high outside IDLE; done  output  1  one-cycle job-end pulse.

Function
REQ-008 SHALL implement states IDLE, IN, DIV1, DIV2, WR, DONE.
REQ-009 IDLE: on start SHALL latch len, dst_addr, max_in, max_value, clear word counter, go IN; len==0 SHALL go directly to DONE.
REQ-010 IN: spect_rdy SHALL be 1 only in IN; a word is accepted when spect_valid & spect_rdy; capture both samples, go DIV1.
REQ-011 Per sample: mag = |x| as 16-bit unsigned (0x8000 -> 32768); numerator = mag * max_value (32-bit); quotient = numerator / max_in, truncated.
REQ-012 DIV1 computes sample 1, DIV2 sample 2, each through one shared divider taking exactly 32 cycles plus 1 cycle launch.
REQ-013 max_in latched 0 SHALL yield result 0 for both samples with no divider launch (DIV states last 1 cycle).
REQ-014 Result SHALL be re-signed: negative input -> two's complement of 16-bit magnitude result.
REQ-015 WR: dma_write=1, dma_addr=current address, dma_writedata={result1,result2}; held stable until dma_rdy.
REQ-016 On dma_rdy in WR: address += 4, counter += 1; counter==len -> DONE, else IN.
REQ-017 DONE: done=1 for exactly one cycle, then IDLE; start while busy SHALL be ignored.
REQ-018 Outputs SHALL be combinational from state; dma_* SHALL be 0 outside WR.
REQ-019 Address SHALL wrap modulo 2^32 without error.

Reset
REQ-020 rst SHALL force IDLE, spect_rdy=0, dma_write=0, dma_addr=0, dma_writedata=0, busy=0, done=0, counters and latched config 0.
REQ-021 rst mid-job SHALL abort the divider and any pending DMA write in the same cycle; no done pulse.

Configuration
REQ-022 Macro SPECT_SCALER_SAT_EN defined: magnitude result SHALL clamp to latched max_value when quotient exceeds it.
REQ-023 SPECT_SCALER_SAT_EN undefined: magnitude result SHALL be quotient[15:0], no clamp.

Structure
REQ-024 Shared package SHALL hold state encoding, DIV_CYCLES=32, DMA word stride 4.
REQ-025 Divider SHALL be sub-module norm_div: 32-bit dividend, 16-bit divisor, start/done, restoring, 32 cycles, 32-bit quotient.

Verification
REQ-026 max_in=0x1000, max_value=0x7FFF, samples 0x0800/0xF800 -> one write {0x3FFF,0xC001} at dst_addr.
REQ-027 max_in=0, len=1, samples 0x1234/0x8000 -> write {0x0000,0x0000}, done 1 cycle after dma_rdy.
REQ-028 max_in=0x1000, max_value=0x7FFF, sample1 0x2000 -> 0x7FFF with SAT_EN, 0xFFFE without.
REQ-029 len=3, dst_addr=0xFFFFFFFC, dma_rdy delayed 5 cycles each -> addresses 0xFFFFFFFC, 0x0, 0x4; writedata stable while waiting.
REQ-030 rst asserted during DIV2 -> next cycle all outputs 0, busy=0, no write issued; new start then runs normally.
REQ-031 spect_valid held low 10 cycles in IN -> spect_rdy stays 1, no state change; start pulse while busy ignored.
